mul_issue_unit: RTL and testbench

- Execute-side front end for the RV32M multiply group (MUL, MULH, MULHSU, MULHU).
- Accepts requests from the ID/EX register and drives the pipelined 32x32 array multiplier: start, signed select, X and Y.
- Tracks in-flight operations, applies the MULHSU sign correction, and selects the 32-bit result half.
- Buffers results in a small FIFO toward writeback, with credit-based backpressure. The multiplier itself cannot stall.

---
 rtl/mul_issue_unit.sv | 162 ++++++++++++++++
 tb/tb_mul_issue_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_issue_unit.sv
// mul_issue_unit: execute-side front end for the RV32M multiply group.
// Issues MUL/MULH/MULHSU/MULHU requests to a pipelined 32x32 array
// multiplier that cannot stall. It tracks in-flight ops, applies the MULHSU
// sign correction, picks the result half and buffers results in a FIFO. A
// credit counter guarantees that the FIFO can never overflow.
//
// Ports:
//   clk, rst                   clock, async active-high reset
//   req_valid_i/req_ready_o    request handshake from ID/EX
//   req_funct3_i               00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   req_rs1_i, req_rs2_i       operands
//   req_rd_i                   destination tag
//   flush_i                    kill all in-flight and buffered ops
//   mul_start_o, mul_signed_o  multiplier control
//   mul_x_o, mul_y_o           multiplier operands
//   mul_result_i               64-bit product, valid MUL_LATENCY edges after issue
//   resp_valid_o/resp_ready_i  result handshake toward writeback
//   resp_data_o, resp_rd_o     result and tag (FIFO head)
module mul_issue_unit #(
    parameter int MUL_LATENCY = 3,
    parameter int FIFO_DEPTH  = 4,
    parameter int TAG_W       = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_funct3_i,
    input  logic [31:0]      req_rs1_i,
    input  logic [31:0]      req_rs2_i,
    input  logic [TAG_W-1:0] req_rd_i,
    input  logic             flush_i,
    output logic             mul_start_o,
    output logic             mul_signed_o,
    output logic [31:0]      mul_x_o,
    output logic [31:0]      mul_y_o,
    input  logic [63:0]      mul_result_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [31:0]      resp_data_o,
    output logic [TAG_W-1:0] resp_rd_o
);
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int LAST = MUL_LATENCY - 1;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } op_e;

    logic [CW-1:0] credits;
    logic          accept;
    logic          pop;
    logic          push;
    logic [31:0]   result;

    // Tracker: one slot per multiplier pipeline stage.
    logic [MUL_LATENCY-1:0] trk_vld;
    logic [1:0]             trk_op   [MUL_LATENCY];
    logic [TAG_W-1:0]       trk_rd   [MUL_LATENCY];
    logic [31:0]            trk_corr [MUL_LATENCY];

    // Result FIFO
    logic [31:0]      fifo_data [FIFO_DEPTH];
    logic [TAG_W-1:0] fifo_rd   [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    // Credits count in-flight plus buffered ops. Hence a full credit count
    // always leaves room in the FIFO for every op still in the multiplier.
    assign req_ready_o = !flush_i && (credits < CW'(FIFO_DEPTH));
    assign accept      = req_valid_i && req_ready_o;
    assign pop         = resp_valid_o && resp_ready_i;

    assign mul_start_o  = accept;
    assign mul_signed_o = accept && (req_funct3_i == OP_MULH);
    assign mul_x_o      = accept ? req_rs1_i : '0;
    assign mul_y_o      = accept ? req_rs2_i : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits <= '0;
        end else if (flush_i) begin
            credits <= '0;
        end else begin
            credits <= credits + CW'(accept) - CW'(pop);
        end
    end

    // The slot at index LAST is valid during the cycle whose closing edge
    // samples mul_result_i. Flush clears all valid bits. accept is already
    // low in a flush cycle, so slot 0 stays clear as well.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trk_vld <= '0;
            for (int i = 0; i < MUL_LATENCY; i++) begin
                trk_op[i]   <= '0;
                trk_rd[i]   <= '0;
                trk_corr[i] <= '0;
            end
        end else begin
            for (int i = LAST; i > 0; i--) begin
                trk_vld[i]  <= trk_vld[i-1] && !flush_i;
                trk_op[i]   <= trk_op[i-1];
                trk_rd[i]   <= trk_rd[i-1];
                trk_corr[i] <= trk_corr[i-1];
            end
            trk_vld[0]  <= accept;
            trk_op[0]   <= req_funct3_i;
            trk_rd[0]   <= req_rd_i;
            // MULHSU runs unsigned. When rs1 is negative the unsigned product
            // overshoots by rs2 * 2^32, so rs2 is subtracted from the high half.
            trk_corr[0] <= (req_funct3_i == OP_MULHSU && req_rs1_i[31]) ? req_rs2_i : '0;
        end
    end

    always_comb begin
        result = mul_result_i[63:32];
        case (trk_op[LAST])
            OP_MUL:    result = mul_result_i[31:0];
            OP_MULHSU: result = mul_result_i[63:32] - trk_corr[LAST];
            default:   result = mul_result_i[63:32];
        endcase
    end

    assign push = trk_vld[LAST] && !flush_i;

    // Pointers wrap naturally since FIFO_DEPTH is a power of two. A push and
    // a pop on a full FIFO write the slot that is being vacated by the pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_rd[i]   <= '0;
            end
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= result;
                fifo_rd[wr_ptr]   <= trk_rd[LAST];
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign resp_valid_o = (count != '0);
    assign resp_data_o  = fifo_data[rd_ptr];
    assign resp_rd_o    = fifo_rd[rd_ptr];

endmodule

// File: tb/tb_mul_issue_unit.sv
// Scoreboard bench for mul_issue_unit. The stimulus pushes expected results.
// A negedge monitor pops an entry and compares it on every accepted response.
// A behavioural pipelined multiplier drives mul_result_i.
module tb_mul_issue_unit;
    localparam int L  = 3;
    localparam int D  = 4;
    localparam int TW = 5;

    logic          clk = 0;
    logic          rst = 1;
    logic          req_valid_i = 0;
    logic          req_ready_o;
    logic [1:0]    req_funct3_i = 0;
    logic [31:0]   req_rs1_i = 0;
    logic [31:0]   req_rs2_i = 0;
    logic [TW-1:0] req_rd_i = 0;
    logic          flush_i = 0;
    logic          mul_start_o;
    logic          mul_signed_o;
    logic [31:0]   mul_x_o;
    logic [31:0]   mul_y_o;
    logic [63:0]   mul_result_i;
    logic          resp_valid_o;
    logic          resp_ready_i = 1;
    logic [31:0]   resp_data_o;
    logic [TW-1:0] resp_rd_o;

    mul_issue_unit #(.MUL_LATENCY(L), .FIFO_DEPTH(D), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_funct3_i(req_funct3_i), .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i),
        .req_rd_i(req_rd_i), .flush_i(flush_i),
        .mul_start_o(mul_start_o), .mul_signed_o(mul_signed_o),
        .mul_x_o(mul_x_o), .mul_y_o(mul_y_o), .mul_result_i(mul_result_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_data_o(resp_data_o), .resp_rd_o(resp_rd_o)
    );

    always #5 clk = ~clk;

    // Pipelined multiplier: the product is presented L edges after start.
    logic [63:0] mpipe [L];
    function automatic logic [63:0] mprod(input logic sgn, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] ex, ey;
        ex = sgn ? {{32{x[31]}}, x} : {32'h0, x};
        ey = sgn ? {{32{y[31]}}, y} : {32'h0, y};
        return ex * ey;
    endfunction
    always @(posedge clk) begin
        mpipe[0] <= mul_start_o ? mprod(mul_signed_o, mul_x_o, mul_y_o) : 64'hDEAD_BEEF_DEAD_BEEF;
        for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_result_i = mpipe[L-1];

    // Architectural reference for RV32M results (used for filler vectors).
    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (op == 2'd1 || op == 2'd2) ? {{32{a[31]}}, a} : {32'h0, a};
        eb = (op == 2'd1) ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ea * eb;
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    typedef struct packed {
        logic [31:0]   data;
        logic [TW-1:0] rd;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every response handed to writeback must match the queue head.
    always @(negedge clk) begin
        if (!rst && resp_valid_o && resp_ready_i) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: got data %0h rd %0d, expected none", resp_data_o, resp_rd_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_data", {32'h0, resp_data_o}, {32'h0, e.data});
                chk("resp_rd", {59'h0, resp_rd_o}, {59'h0, e.rd});
            end
        end
    end

    // Called at posedge+1. Reports whether the request was accepted, and
    // returns at the next posedge+1 with req_valid_i dropped.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TW-1:0] tag, input logic [31:0] exp, output bit acc);
        req_valid_i = 1; req_funct3_i = op; req_rs1_i = a; req_rs2_i = b; req_rd_i = tag;
        @(negedge clk);
        acc = req_ready_o;
        if (acc) sb.push_back({exp, tag});
        @(posedge clk); #1;
        req_valid_i = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc;
        int nacc, tries, vcnt;
        logic [31:0] a;

        // Reset state
        #3;
        chk("rst_resp_valid", {63'h0, resp_valid_o}, 64'h0);
        chk("rst_resp_data", {32'h0, resp_data_o}, 64'h0);
        chk("rst_resp_rd", {59'h0, resp_rd_o}, 64'h0);
        chk("rst_mul_start", {63'h0, mul_start_o}, 64'h0);
        @(negedge clk); rst = 0;
        @(posedge clk); #1;
        chk("rst_req_ready", {63'h0, req_ready_o}, 64'h1);
        chk("idle_mul_x", {32'h0, mul_x_o}, 64'h0);

        // Test 1: MUL 7 * -3, with the issue outputs and latency checked
        req_valid_i = 1; req_funct3_i = 2'b00; req_rs1_i = 32'd7; req_rs2_i = 32'hFFFF_FFFD; req_rd_i = 5;
        @(negedge clk);
        chk("t1_ready", {63'h0, req_ready_o}, 64'h1);
        chk("t1_start", {63'h0, mul_start_o}, 64'h1);
        chk("t1_signed", {63'h0, mul_signed_o}, 64'h0);
        chk("t1_x", {32'h0, mul_x_o}, 64'h7);
        chk("t1_y", {32'h0, mul_y_o}, 64'hFFFF_FFFD);
        sb.push_back({32'hFFFF_FFEB, 5'd5});
        @(posedge clk); #1; req_valid_i = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("t1_valid_c%0d", k), {63'h0, resp_valid_o}, {63'h0, (k == 4)});
            if (k == 1) chk("t1_idle_start", {63'h0, mul_start_o}, 64'h0);
        end
        @(posedge clk); #1;

        // Test 2: back-to-back high-half ops
        issue(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, acc);
        chk("t2_acc0", {63'h0, acc}, 64'h1);
        issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, acc);
        chk("t2_acc1", {63'h0, acc}, 64'h1);
        issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, acc);
        chk("t2_acc2", {63'h0, acc}, 64'h1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("t2_valid_%0d", k), {63'h0, resp_valid_o}, {63'h0, (k >= 1 && k <= 3)});
        end
        @(posedge clk); #1;

        // Test 3: backpressure, only FIFO_DEPTH credits available
        resp_ready_i = 0;
        nacc = 0;
        for (int i = 0; i < 6; i++) begin
            issue(2'b00, 32'd100 + i, 32'd3, TW'(10 + i), 32'd300 + 32'(3 * i), acc);
            chk($sformatf("t3_acc_%0d", i), {63'h0, acc}, {63'h0, (i < 4)});
            if (acc) nacc++;
        end
        chk("t3_naccept", 64'(nacc), 64'd4);
        repeat (5) @(posedge clk);
        #1;
        @(negedge clk);
        chk("t3_full_valid", {63'h0, resp_valid_o}, 64'h1);
        chk("t3_full_ready", {63'h0, req_ready_o}, 64'h0);
        @(posedge clk); #1;
        resp_ready_i = 1;
        @(negedge clk);
        chk("t3_ready_at_pop", {63'h0, req_ready_o}, 64'h0);
        @(negedge clk);
        chk("t3_ready_after_pop", {63'h0, req_ready_o}, 64'h1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("t3_drained", {63'h0, resp_valid_o}, 64'h0);
        chk("t3_sb_empty", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;

        // Test 4: flush kills in-flight ops and blocks the concurrent request
        issue(2'b00, 32'd11, 32'd13, 5'd20, 32'd143, acc);
        issue(2'b00, 32'd17, 32'd19, 5'd21, 32'd323, acc);
        flush_i = 1;
        req_valid_i = 1; req_funct3_i = 2'b00; req_rs1_i = 32'd2; req_rs2_i = 32'd2; req_rd_i = 5'd22;
        @(negedge clk);
        chk("t4_ready_in_flush", {63'h0, req_ready_o}, 64'h0);
        chk("t4_start_in_flush", {63'h0, mul_start_o}, 64'h0);
        @(posedge clk); #1;
        flush_i = 0; req_valid_i = 0;
        sb.delete();
        @(negedge clk);
        chk("t4_ready_after", {63'h0, req_ready_o}, 64'h1);
        vcnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (resp_valid_o) vcnt++;
        end
        chk("t4_no_resp_cycles", 64'(vcnt), 64'd0);
        @(posedge clk); #1;

        // Test 5: fill the FIFO, stream while draining, then reset mid-stream
        resp_ready_i = 0;
        for (int i = 0; i < 4; i++) begin
            a = 32'hF000_0000 ^ (32'(i) * 32'h0123_4567);
            issue(2'(i), a, 32'd5 + 32'(i), TW'(i), ref_res(2'(i), a, 32'd5 + 32'(i)), acc);
            chk($sformatf("t5_fill_%0d", i), {63'h0, acc}, 64'h1);
        end
        repeat (5) @(posedge clk);
        #1;
        resp_ready_i = 1;
        for (int i = 0; i < 6; i++) begin
            a = 32'h8765_4321 + 32'(i) * 32'h1111_0000;
            tries = 0;
            do begin
                issue(2'((i + 2) % 4), a, 32'h9000_0001 + 32'(i),
                      TW'(16 + i), ref_res(2'((i + 2) % 4), a, 32'h9000_0001 + 32'(i)), acc);
                tries++;
            end while (!acc && tries < 10);
            chk($sformatf("t5_stream_acc_%0d", i), {63'h0, acc}, 64'h1);
        end
        #2;
        rst = 1;
        #1;
        chk("t5_rst_valid", {63'h0, resp_valid_o}, 64'h0);
        chk("t5_rst_data", {32'h0, resp_data_o}, 64'h0);
        sb.delete();
        @(negedge clk); rst = 0;
        @(posedge clk); #1;
        issue(2'b00, 32'd3, 32'd4, 5'd9, 32'd12, acc);
        chk("t5_post_rst_acc", {63'h0, acc}, 64'h1);

        // Bounded drain of any outstanding expectations
        tries = 0;
        while (sb.size() != 0 && tries < 40) begin
            @(posedge clk);
            tries++;
        end
        chk("final_sb_empty", 64'(sb.size()), 64'd0);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
